// File: rtl/dram_arb.sv
// dram_arb: shares one 16-bit DRAM port between video fetch, the Z80 memory
// manager and DMA. Each DRAM cycle is 4 clks long and ends on the c3 phase
// strobe; the owner of the next cycle is chosen on c3 and held for 4 clks.
//
// Optional build macro: DRAM_REFRESH_EN
//   defined   - a c3 counter schedules a refresh cycle every REF_PERIOD cycles
//   undefined - no refresh logic, o_dram_rfsh tied low
//
// Ports:
//   i_clk, i_rst          system clock, async active-high reset
//   i_c3                  phase strobe, last clk of each DRAM cycle
//   i_vid_*, o_vid_strobe video read requester
//   i_cpu_*, o_cpu_*      Z80 memory manager requester and handshake
//   i_dma_*, o_dma_*      DMA requester and handshake
//   o_dram_*, i_dram_rddata  DRAM port
//
// Owner states:
//   state     | meaning
//   OWN_IDLE  | no DRAM cycle in progress
//   OWN_VID   | video read cycle
//   OWN_CPU   | Z80 read or byte write cycle
//   OWN_DMA   | DMA word read or write cycle
//   OWN_RFSH  | refresh cycle, no data transfer
module dram_arb #(
  parameter int DMA_STARVE = 8,
  parameter int REF_PERIOD = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_c3,
  input  logic        i_vid_req,
  input  logic [20:0] i_vid_addr,
  output logic        o_vid_strobe,
  input  logic        i_cpu_req,
  input  logic        i_cpu_rnw,
  input  logic [20:0] i_cpu_addr,
  input  logic        i_cpu_wrbsel,
  input  logic [7:0]  i_cpu_wrdata,
  output logic        o_cpu_next,
  output logic        o_cpu_strobe,
  output logic        o_cpu_latch,
  output logic [15:0] o_cpu_rddata,
  input  logic        i_dma_req,
  input  logic        i_dma_rnw,
  input  logic [20:0] i_dma_addr,
  input  logic [15:0] i_dma_wrdata,
  output logic        o_dma_next,
  output logic        o_dma_strobe,
  output logic        o_dram_req,
  output logic        o_dram_rnw,
  output logic [20:0] o_dram_addr,
  output logic [1:0]  o_dram_bsel,
  output logic [15:0] o_dram_wrdata,
  input  logic [15:0] i_dram_rddata,
  output logic        o_dram_rfsh
);

  typedef enum logic [2:0] {
    OWN_IDLE,
    OWN_VID,
    OWN_CPU,
    OWN_DMA,
    OWN_RFSH
  } owner_t;

  localparam logic [3:0] STARVE_TH = 4'(DMA_STARVE);

  owner_t      r_owner;
  owner_t      w_owner_nxt;
  logic [1:0]  r_ph;
  logic [1:0]  w_ph;
  logic [3:0]  r_starve;
  logic        w_dma_force;
  logic        w_rfsh_pend;
  logic        r_rnw;
  logic [20:0] r_addr;
  logic [1:0]  r_bsel;
  logic [15:0] r_wrdata;
  logic        r_dma_next;
  logic [15:0] r_cpu_rddata;
  logic        w_cpu_rd_cycle;

  // Phase counter: 0 on the clk after c3, stops at 3 so a late c3 never
  // produces a second ph==2 strobe within one owner cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ph <= 2'd0;
    end else if (i_c3) begin
      r_ph <= 2'd0;
    end else if (r_ph != 2'd3) begin
      r_ph <= r_ph + 2'd1;
    end
  end

  // An early c3 resyncs the phase to 3, suppressing a not-yet-issued strobe.
  assign w_ph = i_c3 ? 2'd3 : r_ph;

`ifdef DRAM_REFRESH_EN
  localparam int RC_W = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REF_PERIOD - 1);

  logic [RC_W-1:0] r_ref_cnt;
  logic [RC_W-1:0] w_ref_inc;
  logic            r_rfsh_pend;

  assign w_ref_inc = r_ref_cnt + RC_W'(1);

  // Counts c3s; the pending flag forces the following cycle to RFSH, after
  // which the count restarts so refresh lands every REF_PERIOD cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ref_cnt   <= '0;
      r_rfsh_pend <= 1'b0;
    end else if (i_c3) begin
      if (r_rfsh_pend) begin
        r_ref_cnt   <= '0;
        r_rfsh_pend <= 1'b0;
      end else begin
        r_ref_cnt   <= w_ref_inc;
        r_rfsh_pend <= (w_ref_inc == RC_LAST);
      end
    end
  end

  assign w_rfsh_pend = r_rfsh_pend;
  assign o_dram_rfsh = (r_owner == OWN_RFSH);
`else
  // Constant 0 for every legal REF_PERIOD; refresh is never scheduled.
  assign w_rfsh_pend = (REF_PERIOD < 1);
  assign o_dram_rfsh = 1'b0;
`endif

  assign w_dma_force = (r_starve >= STARVE_TH);

  // Owner register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner <= OWN_IDLE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Arbitration, evaluated only on c3
  always_comb begin
    w_owner_nxt = r_owner;
    if (i_c3) begin
      if (w_rfsh_pend) begin
        w_owner_nxt = OWN_RFSH;
      end else if (i_vid_req) begin
        w_owner_nxt = OWN_VID;
      end else if (i_dma_req && w_dma_force) begin
        w_owner_nxt = OWN_DMA;
      end else if (i_cpu_req) begin
        w_owner_nxt = OWN_CPU;
      end else if (i_dma_req) begin
        w_owner_nxt = OWN_DMA;
      end else begin
        w_owner_nxt = OWN_IDLE;
      end
    end
  end

  // DMA starvation counter: counts c3s that DMA asked for and did not get.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve <= 4'd0;
    end else if (i_c3) begin
      if (!i_dma_req || (w_owner_nxt == OWN_DMA)) begin
        r_starve <= 4'd0;
      end else if (r_starve != 4'd15) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

  // DRAM command registers, loaded from the winner on c3. Write data only
  // changes for write cycles; IDLE holds the previous command.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr     <= 21'd0;
      r_rnw      <= 1'b1;
      r_bsel     <= 2'b11;
      r_wrdata   <= 16'd0;
      r_dma_next <= 1'b0;
    end else if (i_c3) begin
      r_dma_next <= (w_owner_nxt == OWN_DMA);
      case (w_owner_nxt)
        OWN_VID: begin
          r_addr <= i_vid_addr;
          r_rnw  <= 1'b1;
          r_bsel <= 2'b11;
        end
        OWN_CPU: begin
          r_addr <= i_cpu_addr;
          r_rnw  <= i_cpu_rnw;
          if (i_cpu_rnw) begin
            r_bsel <= 2'b11;
          end else begin
            r_bsel   <= i_cpu_wrbsel ? 2'b10 : 2'b01;
            r_wrdata <= {i_cpu_wrdata, i_cpu_wrdata};
          end
        end
        OWN_DMA: begin
          r_addr <= i_dma_addr;
          r_rnw  <= i_dma_rnw;
          r_bsel <= 2'b11;
          if (!i_dma_rnw) begin
            r_wrdata <= i_dma_wrdata;
          end
        end
        OWN_RFSH: begin
          r_rnw  <= 1'b1;
          r_bsel <= 2'b11;
        end
        default: begin
        end
      endcase
    end
  end

  assign w_cpu_rd_cycle = (r_owner == OWN_CPU) && r_rnw;

  // CPU read data captured at ph2 and held until the next CPU read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cpu_rddata <= 16'd0;
    end else if (w_cpu_rd_cycle && (w_ph == 2'd2)) begin
      r_cpu_rddata <= i_dram_rddata;
    end
  end

  // Handshake outputs, decoded from the owner and phase
  always_comb begin
    o_vid_strobe = 1'b0;
    o_cpu_strobe = 1'b0;
    o_cpu_latch  = 1'b0;
    o_dma_strobe = 1'b0;
    o_cpu_rddata = r_cpu_rddata;
    case (r_owner)
      OWN_VID: o_vid_strobe = (w_ph == 2'd2);
      OWN_CPU: begin
        if (r_rnw) begin
          o_cpu_strobe = (w_ph == 2'd2);
          o_cpu_latch  = (w_ph == 2'd2) || (w_ph == 2'd3);
          // At ph2 the register has not captured yet; bypass the DRAM bus.
          if (w_ph == 2'd2) begin
            o_cpu_rddata = i_dram_rddata;
          end
        end
      end
      OWN_DMA: o_dma_strobe = (w_ph == 2'd2);
      default: begin
      end
    endcase
  end

  assign o_cpu_next    = !i_vid_req && !w_dma_force && !w_rfsh_pend;
  assign o_dma_next    = r_dma_next;
  assign o_dram_req    = (r_owner != OWN_IDLE);
  assign o_dram_rnw    = r_rnw;
  assign o_dram_addr   = r_addr;
  assign o_dram_bsel   = r_bsel;
  assign o_dram_wrdata = r_wrdata;

endmodule

// File: tb/tb_dram_arb.sv
// Testbench for dram_arb: randomized and directed DRAM-cycle stimulus with a
// queue-based scoreboard. A behavioural model computes each cycle's owner and
// DRAM command at c3; the monitor checks the DUT cycle by cycle.
module tb_dram_arb;
  localparam int STARVE = 8;
  localparam int RP     = 4;

  localparam int O_IDLE = 0;
  localparam int O_VID  = 1;
  localparam int O_CPU  = 2;
  localparam int O_DMA  = 3;
  localparam int O_RFSH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c3 = 1'b0;
  logic        vid_req = 1'b0;
  logic [20:0] vid_addr = '0;
  logic        vid_strobe;
  logic        cpu_req = 1'b0;
  logic        cpu_rnw = 1'b1;
  logic [20:0] cpu_addr = '0;
  logic        cpu_wrbsel = 1'b0;
  logic [7:0]  cpu_wrdata = '0;
  logic        cpu_next, cpu_strobe, cpu_latch;
  logic [15:0] cpu_rddata;
  logic        dma_req = 1'b0;
  logic        dma_rnw = 1'b1;
  logic [20:0] dma_addr = '0;
  logic [15:0] dma_wrdata = '0;
  logic        dma_next, dma_strobe;
  logic        dram_req, dram_rnw, dram_rfsh;
  logic [20:0] dram_addr;
  logic [1:0]  dram_bsel;
  logic [15:0] dram_wrdata;
  logic [15:0] dram_rddata = '0;

  always #5 clk = ~clk;

  dram_arb #(.DMA_STARVE(STARVE), .REF_PERIOD(RP)) dut (
    .i_clk(clk), .i_rst(rst), .i_c3(c3),
    .i_vid_req(vid_req), .i_vid_addr(vid_addr), .o_vid_strobe(vid_strobe),
    .i_cpu_req(cpu_req), .i_cpu_rnw(cpu_rnw), .i_cpu_addr(cpu_addr),
    .i_cpu_wrbsel(cpu_wrbsel), .i_cpu_wrdata(cpu_wrdata),
    .o_cpu_next(cpu_next), .o_cpu_strobe(cpu_strobe), .o_cpu_latch(cpu_latch),
    .o_cpu_rddata(cpu_rddata),
    .i_dma_req(dma_req), .i_dma_rnw(dma_rnw), .i_dma_addr(dma_addr),
    .i_dma_wrdata(dma_wrdata), .o_dma_next(dma_next), .o_dma_strobe(dma_strobe),
    .o_dram_req(dram_req), .o_dram_rnw(dram_rnw), .o_dram_addr(dram_addr),
    .o_dram_bsel(dram_bsel), .o_dram_wrdata(dram_wrdata),
    .i_dram_rddata(dram_rddata), .o_dram_rfsh(dram_rfsh)
  );

  typedef struct {
    int          own;
    logic [20:0] addr;
    logic        rnw;
    logic [1:0]  bsel;
    logic [15:0] wd;
    logic [15:0] rd;
  } txn_t;

  typedef struct {
    bit          vid;
    logic [20:0] vaddr;
    bit          cpu;
    bit          crnw;
    logic [20:0] caddr;
    bit          cbsel;
    logic [7:0]  cwd;
    bit          dma;
    bit          drnw;
    logic [20:0] daddr;
    logic [15:0] dwd;
  } stim_t;

  txn_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  int          m_starve;
  bit          m_pend;
  int          m_rc;
  logic [20:0] m_addr;
  logic        m_rnw;
  logic [1:0]  m_bsel;
  logic [15:0] m_wd;
  bit          m_cpu_next;
  logic [15:0] plan_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    m_pend   = 0;
    m_rc     = 0;
    m_addr   = '0;
    m_rnw    = 1'b1;
    m_bsel   = 2'b11;
    m_wd     = '0;
  endtask

  // Decide the next owner from the priority rules and record the command.
  task automatic arbitrate(input logic [15:0] rd);
    txn_t t;
    int   own;
    bit   starved;
    starved    = (m_starve >= STARVE);
    m_cpu_next = !vid_req && !starved && !m_pend;
    if (m_pend)                own = O_RFSH;
    else if (vid_req)          own = O_VID;
    else if (dma_req && starved) own = O_DMA;
    else if (cpu_req)          own = O_CPU;
    else if (dma_req)          own = O_DMA;
    else                       own = O_IDLE;
    if (!dma_req || own == O_DMA) m_starve = 0;
    else if (m_starve < 15)       m_starve = m_starve + 1;
`ifdef DRAM_REFRESH_EN
    if (m_pend) begin
      m_pend = 0;
      m_rc   = 0;
    end else begin
      m_rc   = m_rc + 1;
      m_pend = (m_rc == RP - 1);
    end
`endif
    case (own)
      O_VID: begin m_addr = vid_addr; m_rnw = 1'b1; m_bsel = 2'b11; end
      O_CPU: begin
        m_addr = cpu_addr;
        m_rnw  = cpu_rnw;
        if (cpu_rnw) m_bsel = 2'b11;
        else begin
          m_bsel = cpu_wrbsel ? 2'b10 : 2'b01;
          m_wd   = {cpu_wrdata, cpu_wrdata};
        end
      end
      O_DMA: begin
        m_addr = dma_addr;
        m_rnw  = dma_rnw;
        m_bsel = 2'b11;
        if (!dma_rnw) m_wd = dma_wrdata;
      end
      O_RFSH: begin m_rnw = 1'b1; m_bsel = 2'b11; end
      default: ;
    endcase
    t.own = own; t.addr = m_addr; t.rnw = m_rnw; t.bsel = m_bsel;
    t.wd = m_wd; t.rd = rd;
    q.push_back(t);
    plan_rd = rd;
  endtask

  // One 4-clk DRAM cycle; arbitration for the following cycle happens at c3.
  task automatic do_cycle(input stim_t s, input logic [15:0] rd, input bit rst_pulse);
    @(posedge clk); #1;
    c3 = 1'b0;
    vid_req = s.vid; vid_addr = s.vaddr;
    cpu_req = s.cpu; cpu_rnw = s.crnw; cpu_addr = s.caddr;
    cpu_wrbsel = s.cbsel; cpu_wrdata = s.cwd;
    dma_req = s.dma; dma_rnw = s.drnw; dma_addr = s.daddr; dma_wrdata = s.dwd;
    dram_rddata = 16'($urandom);
    @(posedge clk); #1;
    dram_rddata = 16'($urandom);
    if (rst_pulse) begin
      rst = 1'b1;
      model_reset();
    end
    @(posedge clk); #1;
    dram_rddata = plan_rd;
    @(posedge clk); #1;
    dram_rddata = 16'($urandom);
    if (rst_pulse) rst = 1'b0;
    c3 = 1'b1;
    arbitrate(16'($urandom));
    if (rd !== 16'hxxxx) begin
      q[q.size()-1].rd = rd;
      plan_rd = rd;
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.vid   = ($urandom_range(0, 3) == 0);
    s.vaddr = 21'($urandom);
    s.cpu   = $urandom_range(0, 1) == 1;
    s.crnw  = $urandom_range(0, 1) == 1;
    s.caddr = 21'($urandom);
    s.cbsel = $urandom_range(0, 1) == 1;
    s.cwd   = 8'($urandom);
    s.dma   = $urandom_range(0, 1) == 1;
    s.drnw  = $urandom_range(0, 1) == 1;
    s.daddr = 21'($urandom);
    s.dwd   = 16'($urandom);
    return s;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = rand_stim();
    s.vid = 0; s.cpu = 0; s.dma = 0;
    return s;
  endfunction

  // Monitor: tracks the DRAM-cycle position from c3 and checks every clk.
  initial begin
    int          pos;
    bit          prev_c3;
    bit          rst_q;
    bit          cpu_rd;
    txn_t        cur;
    logic [15:0] last_rd;
    logic [15:0] exp_rd;
    pos = 99; prev_c3 = 0; rst_q = 1; last_rd = '0;
    cur.own = O_IDLE; cur.addr = '0; cur.rnw = 1'b1; cur.bsel = 2'b11;
    cur.wd = '0; cur.rd = '0;
    forever begin
      @(posedge rst or negedge clk);
      if (rst && !rst_q) begin
        rst_q = 1;
        #1;
        chk("rst_dram_req", 32'(dram_req), 32'd0);
        chk("rst_cpu_strobe", 32'(cpu_strobe), 32'd0);
        chk("rst_cpu_latch", 32'(cpu_latch), 32'd0);
        chk("rst_bsel", 32'(dram_bsel), 32'd3);
        chk("rst_rnw", 32'(dram_rnw), 32'd1);
        chk("rst_addr", 32'(dram_addr), 32'd0);
        chk("rst_cpu_rddata", 32'(cpu_rddata), 32'd0);
        cur.own = O_IDLE; cur.addr = '0; cur.rnw = 1'b1; cur.bsel = 2'b11;
        cur.wd = '0; cur.rd = '0;
        last_rd = '0;
        continue;
      end
      rst_q = rst;
      pos = prev_c3 ? 0 : ((pos < 99) ? pos + 1 : 99);
      prev_c3 = c3;
      if (pos == 0 && !rst) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard_empty at %0t: got no expected cycle, required one", $time);
        end else begin
          cur = q.pop_front();
        end
      end
      cpu_rd = (cur.own == O_CPU) && cur.rnw;
      chk("dram_req", 32'(dram_req), 32'(cur.own != O_IDLE));
      chk("dram_rfsh", 32'(dram_rfsh), 32'(cur.own == O_RFSH));
      chk("dram_addr", 32'(dram_addr), 32'(cur.addr));
      chk("dram_rnw", 32'(dram_rnw), 32'(cur.rnw));
      chk("dram_bsel", 32'(dram_bsel), 32'(cur.bsel));
      chk("dram_wrdata", 32'(dram_wrdata), 32'(cur.wd));
      chk("dma_next", 32'(dma_next), 32'(cur.own == O_DMA));
      chk("vid_strobe", 32'(vid_strobe), 32'(cur.own == O_VID && pos == 2));
      chk("cpu_strobe", 32'(cpu_strobe), 32'(cpu_rd && pos == 2));
      chk("dma_strobe", 32'(dma_strobe), 32'(cur.own == O_DMA && pos == 2));
      chk("cpu_latch", 32'(cpu_latch), 32'(cpu_rd && (pos == 2 || pos == 3)));
      exp_rd = (cpu_rd && pos == 2) ? cur.rd : last_rd;
      chk("cpu_rddata", 32'(cpu_rddata), 32'(exp_rd));
      if (cpu_rd && pos == 2) last_rd = cur.rd;
      if (c3 && !rst) chk("cpu_next", 32'(cpu_next), 32'(m_cpu_next));
    end
  end

  // Driver
  initial begin
    stim_t s;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // no c3 yet: everything must stay idle even with all requests up
    vid_req = 1; cpu_req = 1; dma_req = 1;
    repeat (10) @(posedge clk);

    // CPU read of 012345 returning BEEF
    s = idle_stim(); s.cpu = 1; s.crnw = 1; s.caddr = 21'h012345;
    do_cycle(s, 16'hBEEF, 0);
    // CPU high-byte write of A5
    s = idle_stim(); s.cpu = 1; s.crnw = 0; s.cbsel = 1; s.cwd = 8'hA5;
    do_cycle(s, 16'hxxxx, 0);
    // video and CPU together, then CPU alone
    s = idle_stim(); s.vid = 1; s.cpu = 1; s.crnw = 1;
    do_cycle(s, 16'hxxxx, 0);
    do_cycle(s, 16'hxxxx, 0);
    s.vid = 0;
    do_cycle(s, 16'hxxxx, 0);
    // DMA starvation behind a CPU that never lets go
    s = idle_stim(); s.cpu = 1; s.crnw = 1; s.dma = 1; s.drnw = 1;
    for (int i = 0; i < 12; i++) begin
      s.caddr = 21'($urandom);
      do_cycle(s, 16'hxxxx, 0);
    end
    // reset during ph1 of a CPU read
    s = idle_stim(); s.cpu = 1; s.crnw = 1;
    do_cycle(s, 16'h1234, 0);
    s = idle_stim();
    do_cycle(s, 16'hxxxx, 1);
    do_cycle(s, 16'hxxxx, 0);
    // all requests high (refresh spacing when enabled)
    s = rand_stim(); s.vid = 1; s.cpu = 1; s.dma = 1;
    for (int i = 0; i < 12; i++) do_cycle(s, 16'hxxxx, 0);
    // random traffic
    for (int i = 0; i < 300; i++) do_cycle(rand_stim(), 16'hxxxx, 0);
    s = idle_stim();
    do_cycle(s, 16'hxxxx, 0);
    do_cycle(s, 16'hxxxx, 0);
    @(posedge clk); #1 c3 = 1'b0;
    repeat (6) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_arb.md
Name: dram_arb

Overview:
- Shares the single 16-bit DRAM port between three requesters: video fetch, Z80 memory manager and DMA.
- Runs 4-clk DRAM cycles aligned to the system c3 phase strobe and grants one owner per cycle.
- Generates the cpu_next / cpu_strobe / cpu_latch handshake the Z80 memory manager consumes, plus the equivalent DMA and video strobes.

Parameters:
DMA_STARVE, 8, consecutive lost arbitrations after which DMA is forced ahead of CPU (1..15)
REF_PERIOD, 64, DRAM cycles between refresh cycles (used only with DRAM_REFRESH_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
c3  in  1  phase strobe, last clk of each 4-clk DRAM cycle
vid_req  in  1  video wants next cycle (read only)
vid_addr  in  21  video word address
vid_strobe  out  1  video read data valid on dram_rddata
cpu_req  in  1  Z80 request (level, sampled at c3)
cpu_rnw  in  1  1=read, 0=write
cpu_addr  in  21  Z80 word address
cpu_wrbsel  in  1  byte select for writes (0=low, 1=high)
cpu_wrdata  in  8  Z80 write byte
cpu_next  out  1  CPU would win arbitration at the coming c3
cpu_strobe  out  1  one-clk pulse: CPU read data valid, write cache
cpu_latch  out  1  CPU read data on cpu_rddata valid this clk
cpu_rddata  out  16  CPU read data
dma_req  in  1  DMA request
dma_rnw  in  1  DMA direction
dma_addr  in  21  DMA word address
dma_wrdata  in  16  DMA write word
dma_next  out  1  DMA granted for the cycle starting after this c3
dma_strobe  out  1  DMA read data valid / write accepted
dram_req  out  1  DRAM cycle active
dram_rnw  out  1  DRAM direction
dram_addr  out  21  DRAM word address
dram_bsel  out  2  byte enables, [1]=high byte
dram_wrdata  out  16  DRAM write data
dram_rddata  in  16  DRAM read data, valid at phase 2 of a read cycle
dram_rfsh  out  1  refresh cycle in progress

Behaviour:
- Phase counter ph[1:0]: 0 on the clk after c3, then increments; c3 also forces ph=3 (resync).
- Owner state: IDLE, VID, CPU, DMA, RFSH. Loaded only on c3; held for the next 4 clks.
- Priority at c3: RFSH (if pending) > VID > DMA (if starved) > CPU > DMA > IDLE.
- cpu_next (combinational) = !vid_req && !dma_force && !rfsh_pend. It does not depend on cpu_req.
- dma_next = registered on c3 when DMA is granted.
- Starvation counter (4 bit):
  - Increments at c3 when dma_req && owner!=DMA.
  - Clears when DMA is granted or when dma_req is low.
  - Saturates at 15.
  - dma_force = count >= DMA_STARVE.
- Outputs are registered on c3 from the winner's inputs:
  - dram_addr/dram_rnw/dram_wrdata.
  - dram_bsel = 2'b11 for reads and DMA writes.
  - CPU write: dram_bsel = cpu_wrbsel ? 2'b10 : 2'b01, dram_wrdata = {cpu_wrdata, cpu_wrdata}.
- dram_req = 1 for the whole cycle when owner!=IDLE.
- Strobes fire at ph==2 of the owner's cycle:
  - Read strobes: vid_strobe, cpu_strobe, dma_strobe pulse 1 clk.
  - Writes: dma_strobe pulses at ph==2; cpu_strobe stays low.
- cpu_latch = 1 at ph 2 and 3 of a CPU read cycle. cpu_rddata is registered at ph 2 and holds until the next CPU read.
- Request deasserted mid-cycle: the cycle completes; strobes are still issued.
- No c3 ever seen: owner stays IDLE and all strobes stay 0.
- Reset (async, any time):
  - Owner=IDLE, ph=0, counters=0.
  - All outputs 0, except dram_bsel=2'b11 and dram_rnw=1.
  - An in-flight cycle is abandoned and no strobe is issued.

Optional Feature:
DRAM_REFRESH_EN:
- Defined: a cycle counter counts c3s. At REF_PERIOD-1 it sets rfsh_pend.
  - The next c3 grants RFSH regardless of other requests.
  - dram_rfsh=1 and dram_req=1 for that cycle; no strobes are issued.
  - rfsh_pend clears and the counter wraps to 0.
- Undefined: no counter, dram_rfsh tied 0, RFSH state unreachable.

Test Plan:
- CPU read only, cpu_addr=21'h012345, dram_rddata=16'hBEEF at ph2:
  - dram_addr=21'h012345 and dram_bsel=2'b11 one clk after c3.
  - cpu_strobe at ph2, cpu_latch at ph2-3, cpu_rddata=16'hBEEF.
- CPU write cpu_wrbsel=1, cpu_wrdata=8'hA5 -> dram_bsel=2'b10, dram_wrdata=16'hA5A5, dram_rnw=0, no cpu_strobe.
- vid_req and cpu_req together at c3 -> owner VID, cpu_next=0 before c3, vid_strobe at ph2; CPU is granted at the next c3 after vid_req drops.
- cpu_req held high, dma_req high, DMA_STARVE=8 -> 8 CPU cycles, then cpu_next=0 and one DMA cycle with dma_strobe; the counter returns to 0.
- Assert rst at ph1 of a CPU read -> outputs reset immediately, no cpu_strobe; after release the first grant happens at the next c3.
- With DRAM_REFRESH_EN and REF_PERIOD=4, all requests high -> every 4th cycle dram_rfsh=1 and no strobes; without the macro, dram_rfsh stays 0.
